pwm_duty_sched: RTL and testbench

Duty-cycle scheduler for the 11-bit complementary PWM generator. It accepts target duty values through a valid/ready handshake and ramps the PWM `duty` input toward the target in bounded steps. Duty changes are applied only at PWM period boundaries, so the PWM never sees a mid-period glitch. An emergency stop forces the zero-drive midpoint duty.

---
 rtl/pwm_duty_sched.sv | 133 +++++++++++++
 tb/tb_pwm_duty_sched.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sched.sv
// Duty-cycle scheduler for the 11-bit complementary PWM: ramps duty toward an accepted
// target in bounded steps at period boundaries. Optional clamp: PWM_DUTY_SCHED_DUTY_CLAMP_EN.
module pwm_duty_sched #(
  parameter int STEP     = 16,
  parameter int RAMP_DIV = 4,
  parameter int MIN_DUTY = 64,
  parameter int MAX_DUTY = 1983
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        estop,
  input  logic        prd_wrap,
  input  logic [10:0] tgt_duty,
  input  logic        tgt_vld,
  output logic        tgt_rdy,
  output logic [10:0] duty,
  output logic        ramping,
  output logic        ramp_done
);

  typedef enum logic [1:0] {IDLE, RAMP, STOP} state_t;

  localparam int          DIV_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [11:0] STEP_W  = 12'(STEP);
  localparam logic [10:0] STEP_D  = 11'(STEP);
  localparam logic [10:0] MID     = 11'd1024;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  state_t            r_state, w_state_nxt;
  logic [10:0]       r_tgt, w_tgt_nxt;
  logic [10:0]       r_duty, w_duty_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt;
  logic              r_ramping, r_ramp_done, w_done_nxt;
  logic              r_rst_q;

  logic              w_accept;
  logic [10:0]       w_tgt_in;
  logic signed [11:0] w_diff;
  logic [11:0]       w_mag;
  logic [10:0]       w_stepped;
  logic              w_update;

`ifdef PWM_DUTY_SCHED_DUTY_CLAMP_EN
  localparam logic [10:0] LO = 11'(MIN_DUTY);
  localparam logic [10:0] HI = 11'(MAX_DUTY);
  assign w_tgt_in = (tgt_duty < LO) ? LO : (tgt_duty > HI) ? HI : tgt_duty;
`else
  assign w_tgt_in = tgt_duty;
`endif

  // estop gates readiness combinationally so no target slips in on the stop edge.
  assign tgt_rdy  = ~r_rst_q & ~estop;
  assign w_accept = tgt_vld & tgt_rdy;

  // Magnitude above STEP guarantees duty +/- STEP stays inside 0..2047 and short of target.
  assign w_diff    = $signed({1'b0, r_tgt}) - $signed({1'b0, r_duty});
  assign w_mag     = w_diff[11] ? 12'(-w_diff) : 12'(w_diff);
  assign w_stepped = (w_mag <= STEP_W) ? r_tgt
                   : w_diff[11]        ? r_duty - STEP_D
                   :                     r_duty + STEP_D;
  assign w_update  = (r_state == RAMP) && prd_wrap && (r_div == DIV_LAST);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_duty_nxt  = r_duty;
    w_div_nxt   = r_div;
    w_done_nxt  = 1'b0;
    if (estop) begin
      w_state_nxt = STOP;
      w_tgt_nxt   = MID;
      w_duty_nxt  = MID;
      w_div_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE, STOP: begin
          w_state_nxt = IDLE;
          if (w_accept) begin
            w_tgt_nxt = w_tgt_in;
            if (w_tgt_in != r_duty) begin
              w_state_nxt = RAMP;
              w_div_nxt   = '0;
            end
          end
        end
        RAMP: begin
          if (prd_wrap) begin
            if (w_update) begin
              w_div_nxt  = '0;
              w_duty_nxt = w_stepped;
            end else begin
              w_div_nxt = r_div + 1'b1;
            end
          end
          // The update above used the old target; a same-edge accept only matters from here on.
          if (w_accept) w_tgt_nxt = w_tgt_in;
          if (w_duty_nxt == w_tgt_nxt) begin
            w_state_nxt = IDLE;
            w_done_nxt  = w_update;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tgt       <= MID;
      r_duty      <= MID;
      r_div       <= '0;
      r_ramping   <= 1'b0;
      r_ramp_done <= 1'b0;
      r_rst_q     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_tgt       <= w_tgt_nxt;
      r_duty      <= w_duty_nxt;
      r_div       <= w_div_nxt;
      r_ramping   <= (w_state_nxt == RAMP);
      r_ramp_done <= w_done_nxt;
      r_rst_q     <= 1'b0;
    end
  end

  assign duty      = r_duty;
  assign ramping   = r_ramping;
  assign ramp_done = r_ramp_done;

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Directed bench for pwm_duty_sched: cycle-accurate vector table plus saturation,
// and reset-mid-ramp sequences.
module tb_pwm_duty_sched;

  logic        clk = 1'b0;
  logic        rst, estop, prd_wrap, tgt_vld;
  logic [10:0] tgt_duty;
  logic        tgt_rdy, ramping, ramp_done;
  logic [10:0] duty;

  int n_checks = 0;
  int n_pass   = 0;

  pwm_duty_sched dut (
    .clk(clk), .rst(rst), .estop(estop), .prd_wrap(prd_wrap),
    .tgt_duty(tgt_duty), .tgt_vld(tgt_vld), .tgt_rdy(tgt_rdy),
    .duty(duty), .ramping(ramping), .ramp_done(ramp_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [10:0] tgt;
    logic        wrap;
    logic        stop;
    logic [10:0] e_duty;
    logic        e_rdy;
    logic        e_ramp;
    logic        e_done;
  } vec_t;

  vec_t vq[$];

`ifdef PWM_DUTY_SCHED_DUTY_CLAMP_EN
  localparam int SAT_HI = 1983;
  localparam int SAT_LO = 64;
`else
  localparam int SAT_HI = 2047;
  localparam int SAT_LO = 0;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cycle(input logic v, input logic [10:0] t, input logic w, input logic s);
    tgt_vld = v; tgt_duty = t; prd_wrap = w; estop = s;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input int t, input logic w, input logic s,
                     input int d, input logic r, input logic rp, input logic dn);
    vec_t x;
    x.vld = v; x.tgt = 11'(t); x.wrap = w; x.stop = s;
    x.e_duty = 11'(d); x.e_rdy = r; x.e_ramp = rp; x.e_done = dn;
    vq.push_back(x);
  endtask

  task automatic add_wraps(input int n, input int d);
    for (int k = 0; k < n; k++) add(0, 0, 1, 0, d, 1, 1, 0);
  endtask

  // Three non-qualifying wraps then the updating wrap.
  task automatic add_step(input int prev, input int nxt, input logic last);
    add_wraps(3, prev);
    add(0, 0, 1, 0, nxt, 1, ~last, last);
  endtask

  task automatic ramp_to(input int tgt, input int exp_final, input string tag);
    int prev, bad, dones, cyc;
    logic up;
    prev = int'(duty); bad = 0; dones = 0;
    up = (exp_final > prev);
    cycle(1, 11'(tgt), 0, 0);
    for (cyc = 0; cyc < 1000; cyc++) begin
      cycle(0, 0, 1, 0);
      if (int'(duty) != prev) begin
        if (up ? (int'(duty) < prev || int'(duty) > exp_final)
               : (int'(duty) > prev || int'(duty) < exp_final)) bad++;
        if (int'(duty) != exp_final && (up ? int'(duty) - prev : prev - int'(duty)) != 16) bad++;
        prev = int'(duty);
      end
      if (ramp_done) begin
        dones++;
        break;
      end
    end
    check({tag, "_timeout"}, int'(cyc < 1000), 1);
    check({tag, "_final"}, int'(duty), exp_final);
    check({tag, "_bad_steps"}, bad, 0);
    check({tag, "_done"}, dones, 1);
    cycle(0, 0, 1, 0);
    check({tag, "_done_clr"}, int'(ramp_done), 0);
    check({tag, "_hold"}, int'(duty), exp_final);
  endtask

  initial begin
    rst = 1'b1; estop = 1'b0; prd_wrap = 1'b0; tgt_vld = 1'b0; tgt_duty = '0;

    // Main ramp, redirect, estop and coincident accept/update vectors.
    add(1, 1024, 0, 0, 1024, 1, 0, 0);
    add(0, 0,    0, 0, 1024, 1, 0, 0);
    add(1, 1100, 0, 0, 1024, 1, 1, 0);
    add_step(1024, 1040, 0);
    add_step(1040, 1056, 0);
    add_step(1056, 1072, 0);
    add_step(1072, 1088, 0);
    add_step(1088, 1100, 1);
    add(0, 0, 0, 0, 1100, 1, 0, 0);
    add(0, 0, 0, 1, 1024, 0, 0, 0);
    add(0, 0, 0, 0, 1024, 1, 0, 0);
    add(1, 1100, 0, 0, 1024, 1, 1, 0);
    add_step(1024, 1040, 0);
    add_step(1040, 1056, 0);
    add_wraps(2, 1056);
    add(1, 1000, 0, 0, 1056, 1, 1, 0);
    add(0, 0,    1, 0, 1056, 1, 1, 0);
    add(0, 0,    1, 0, 1040, 1, 1, 0);
    add_step(1040, 1024, 0);
    add_step(1024, 1008, 0);
    add_step(1008, 1000, 1);
    add(0, 0, 0, 0, 1000, 1, 0, 0);
    add(1, 1100, 0, 0, 1000, 1, 1, 0);
    add_wraps(2, 1000);
    add(0, 0,   0, 1, 1024, 0, 0, 0);
    add(1, 500, 0, 1, 1024, 0, 0, 0);
    add(0, 0,   0, 0, 1024, 1, 0, 0);
    add(1, 1030, 0, 0, 1024, 1, 1, 0);
    add_step(1024, 1030, 1);
    add(1, 1040, 0, 0, 1030, 1, 1, 0);
    add_wraps(3, 1030);
    add(1, 1040, 1, 0, 1040, 1, 0, 1);
    add(1, 1056, 0, 0, 1040, 1, 1, 0);
    add_wraps(3, 1040);
    add(1, 1100, 1, 0, 1056, 1, 1, 0);
    add_step(1056, 1072, 0);
    add_step(1072, 1088, 0);
    add_step(1088, 1100, 1);
    add(0, 0, 0, 0, 1100, 1, 0, 0);

    // Reset state and the one-cycle tgt_rdy delay.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_duty", int'(duty), 1024);
    check("rst_rdy", int'(tgt_rdy), 0);
    check("rst_ramping", int'(ramping), 0);
    check("rst_done", int'(ramp_done), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_rdy", int'(tgt_rdy), 1);
    check("post_rst_duty", int'(duty), 1024);

    foreach (vq[i]) begin
      cycle(vq[i].vld, vq[i].tgt, vq[i].wrap, vq[i].stop);
      check($sformatf("row%0d_duty", i), int'(duty), int'(vq[i].e_duty));
      check($sformatf("row%0d_rdy", i), int'(tgt_rdy), int'(vq[i].e_rdy));
      check($sformatf("row%0d_ramping", i), int'(ramping), int'(vq[i].e_ramp));
      check($sformatf("row%0d_done", i), int'(ramp_done), int'(vq[i].e_done));
    end

    // Saturation at the range ends.
    ramp_to(2047, SAT_HI, "sat_hi");
    ramp_to(0, SAT_LO, "sat_lo");

    // Reset mid-ramp discards the pending target.
    cycle(1, 11'd1100, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 0);
    check("mid_ramp_moved", int'(duty), SAT_LO + 16);
    rst = 1'b1;
    cycle(0, 0, 0, 0);
    check("mid_rst_duty", int'(duty), 1024);
    check("mid_rst_ramping", int'(ramping), 0);
    check("mid_rst_done", int'(ramp_done), 0);
    check("mid_rst_rdy", int'(tgt_rdy), 0);
    rst = 1'b0;
    cycle(0, 0, 0, 0);
    check("mid_rst_rdy_back", int'(tgt_rdy), 1);
    for (int k = 0; k < 8; k++) cycle(0, 0, 1, 0);
    check("no_pending_duty", int'(duty), 1024);
    check("no_pending_ramping", int'(ramping), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
